// File: rtl/m_stage_dmem_if.sv
// M-stage to data-RAM bus: E/M pipeline register outputs in, W-stage results out.
// master = pipeline side, slave = data RAM.
interface m_stage_dmem_if;
    logic [31:0] INSTR_M;
    logic [31:0] ALU_OUT_M;
    logic [31:0] FRead_Data_2_M;
    logic [31:0] PC_M;
    logic        MEM_WRITE_ENABLED_M;
    logic        STALL_M;
    logic [31:0] MEM_READ_DATA_W;
    logic        EXC_W;
    logic [31:0] EXC_PC_W;
    logic [31:0] BAD_ADDR_W;

    modport master (
        output INSTR_M,
        output ALU_OUT_M,
        output FRead_Data_2_M,
        output PC_M,
        output MEM_WRITE_ENABLED_M,
        input  STALL_M,
        input  MEM_READ_DATA_W,
        input  EXC_W,
        input  EXC_PC_W,
        input  BAD_ADDR_W
    );

    modport slave (
        input  INSTR_M,
        input  ALU_OUT_M,
        input  FRead_Data_2_M,
        input  PC_M,
        input  MEM_WRITE_ENABLED_M,
        output STALL_M,
        output MEM_READ_DATA_W,
        output EXC_W,
        output EXC_PC_W,
        output BAD_ADDR_W
    );
endinterface

// File: rtl/m_stage_dmem.sv
// Memory-stage data RAM: MIPS byte/half/word loads and stores, registered W-stage results,
// address exceptions, and a post-reset zeroing sweep that stalls the pipeline.
// Optional macro DMEM_STORE_LOG_EN: print one line per committed store (simulation only).
// ADDR_WIDTH is assumed <= 29 so the byte range fits in 32 bits.
module m_stage_dmem #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input logic           clk,
    input logic           reset,
    m_stage_dmem_if.slave bus
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    localparam logic [5:0] OpLb  = 6'h20;
    localparam logic [5:0] OpLh  = 6'h21;
    localparam logic [5:0] OpLw  = 6'h23;
    localparam logic [5:0] OpLbu = 6'h24;
    localparam logic [5:0] OpLhu = 6'h25;
    localparam logic [5:0] OpSb  = 6'h28;
    localparam logic [5:0] OpSh  = 6'h29;
    localparam logic [5:0] OpSw  = 6'h2B;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    exc_q, exc_d;
    logic [31:0]             exc_pc_q, exc_pc_d;
    logic [31:0]             bad_addr_q, bad_addr_d;

    logic [31:0]             mem_q [Depth];

    logic [5:0]              opcode;
    logic                    is_load, is_store, is_byte, is_half, is_word, sign_ext;
    logic [31:0]             off;
    logic [ADDR_WIDTH-1:0]   word;
    logic [1:0]              lane;
    logic                    misalign, oob, access, exc, run, store_commit;
    logic [31:0]             old_word, store_data, merged;
    logic [3:0]              be;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [31:0]             ld_data;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [31:0]             mem_wdata;
    logic                    unused_instr;

    assign unused_instr = ^bus.INSTR_M[25:0];

    // Decode the opcode into access size, direction and extension.
    always_comb begin
        opcode   = bus.INSTR_M[31:26];
        is_load  = 1'b0;
        is_store = 1'b0;
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        sign_ext = 1'b0;
        case (opcode)
            OpLb:    begin is_load = 1'b1;  is_byte = 1'b1; sign_ext = 1'b1; end
            OpLh:    begin is_load = 1'b1;  is_half = 1'b1; sign_ext = 1'b1; end
            OpLw:    begin is_load = 1'b1;  is_word = 1'b1; end
            OpLbu:   begin is_load = 1'b1;  is_byte = 1'b1; end
            OpLhu:   begin is_load = 1'b1;  is_half = 1'b1; end
            OpSb:    begin is_store = 1'b1; is_byte = 1'b1; end
            OpSh:    begin is_store = 1'b1; is_half = 1'b1; end
            OpSw:    begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    // Address split, exception detection, and load extraction / store merge.
    always_comb begin
        run      = (state_q == StRun);
        off      = bus.ALU_OUT_M - BASE_ADDR;
        word     = off[ADDR_WIDTH+1:2];
        lane     = off[1:0];
        misalign = (is_half & lane[0]) | (is_word & (lane != 2'b00));
        oob      = (off >> (ADDR_WIDTH + 2)) != 32'd0;
        // A store without its write qualifier is not an access at all.
        access   = is_load | (is_store & bus.MEM_WRITE_ENABLED_M);
        exc      = run & access & (misalign | oob);
        store_commit = run & is_store & bus.MEM_WRITE_ENABLED_M & ~exc;

        old_word = mem_q[word];
        ld_byte  = old_word[{lane, 3'b000} +: 8];
        ld_half  = old_word[{lane[1], 4'b0000} +: 16];
        ld_data  = 32'd0;
        if (is_byte) begin
            ld_data = sign_ext ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
        end else if (is_half) begin
            ld_data = sign_ext ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
        end else if (is_word) begin
            ld_data = old_word;
        end

        be         = 4'b0000;
        store_data = bus.FRead_Data_2_M;
        if (is_byte) begin
            be         = 4'b0001 << lane;
            store_data = {4{bus.FRead_Data_2_M[7:0]}};
        end else if (is_half) begin
            be         = lane[1] ? 4'b1100 : 4'b0011;
            store_data = {2{bus.FRead_Data_2_M[15:0]}};
        end else if (is_word) begin
            be         = 4'b1111;
        end
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? store_data[8*i +: 8] : old_word[8*i +: 8];
        end
    end

    // Next-state for the sweep FSM and the W-stage registers.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rdata_d    = 32'd0;
        exc_d      = 1'b0;
        exc_pc_d   = exc_pc_q;
        bad_addr_d = bad_addr_q;
        mem_we     = 1'b0;
        mem_waddr  = word;
        mem_wdata  = merged;
        if (state_q == StInit) begin
            mem_we     = 1'b1;
            mem_waddr  = idx_q;
            mem_wdata  = 32'd0;
            idx_d      = idx_q + 1'b1;
            exc_pc_d   = 32'd0;
            bad_addr_d = 32'd0;
            if (idx_q == ADDR_WIDTH'(Depth - 1)) begin
                state_d = StRun;
            end
        end else begin
            mem_we = store_commit;
            if (exc) begin
                exc_d      = 1'b1;
                exc_pc_d   = bus.PC_M;
                bad_addr_d = bus.ALU_OUT_M;
            end else if (is_load) begin
                rdata_d = ld_data;
            end
        end
    end

    // State and W-stage registers; reset restarts the sweep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StInit;
            idx_q      <= '0;
            rdata_q    <= 32'd0;
            exc_q      <= 1'b0;
            exc_pc_q   <= 32'd0;
            bad_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rdata_q    <= rdata_d;
            exc_q      <= exc_d;
            exc_pc_q   <= exc_pc_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    // Single write port shared by the init sweep and committed stores.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
`ifdef DMEM_STORE_LOG_EN
        if (store_commit) begin
            $display("@%h: *%h <= %h", bus.PC_M, BASE_ADDR + (32'(word) << 2), merged);
        end
`else
`endif
    end

    assign bus.STALL_M         = (state_q == StInit);
    assign bus.MEM_READ_DATA_W = rdata_q;
    assign bus.EXC_W           = exc_q;
    assign bus.EXC_PC_W        = exc_pc_q;
    assign bus.BAD_ADDR_W      = bad_addr_q;

endmodule

// File: tb/tb_m_stage_dmem.sv
// Directed bench for m_stage_dmem with a 16-word array.
module tb_m_stage_dmem;

    localparam int unsigned Aw = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    m_stage_dmem_if bus ();

    m_stage_dmem #(
        .ADDR_WIDTH (Aw),
        .BASE_ADDR  (32'h0000_0000)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one M-stage request and advance one edge.
    task automatic do_op(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] pc, input logic we);
        bus.INSTR_M             = {opc, 26'h0};
        bus.ALU_OUT_M           = addr;
        bus.FRead_Data_2_M      = data;
        bus.PC_M                = pc;
        bus.MEM_WRITE_ENABLED_M = we;
        tick();
    endtask

    // Count stall cycles after reset release, noting any W output leaking during the sweep.
    task automatic wait_sweep(output int n, output logic leak);
        n    = 0;
        leak = 1'b0;
        while (bus.STALL_M && n < 100) begin
            tick();
            n++;
            if (bus.MEM_READ_DATA_W != 0 || bus.EXC_W != 0 || bus.EXC_PC_W != 0 ||
                bus.BAD_ADDR_W != 0) begin
                leak = 1'b1;
            end
        end
    endtask

    int   n_stall;
    logic leak;

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.INSTR_M             = 32'h0;
        bus.ALU_OUT_M           = 32'h0;
        bus.FRead_Data_2_M      = 32'h0;
        bus.PC_M                = 32'h0;
        bus.MEM_WRITE_ENABLED_M = 1'b0;
        tick();
        tick();
        check_eq("rst_stall", 32'(bus.STALL_M), 32'd1);
        check_eq("rst_rdata", bus.MEM_READ_DATA_W, 32'h0);
        check_eq("rst_exc", 32'(bus.EXC_W), 32'd0);
        check_eq("rst_exc_pc", bus.EXC_PC_W, 32'h0);
        check_eq("rst_bad", bus.BAD_ADDR_W, 32'h0);

        // A store presented during the sweep must be ignored.
        bus.INSTR_M             = {6'h2B, 26'h0};
        bus.ALU_OUT_M           = 32'h3C;
        bus.FRead_Data_2_M      = 32'hFFFF_FFFF;
        bus.MEM_WRITE_ENABLED_M = 1'b1;
        reset = 1'b1;
        wait_sweep(n_stall, leak);
        check_eq("sweep_len", 32'(n_stall), 32'd16);
        check_eq("sweep_hold", 32'(leak), 32'd0);

        do_op(6'h23, 32'h3C, 32'h0, 32'h1000, 1'b0);
        check_eq("lw_3c_cleared", bus.MEM_READ_DATA_W, 32'h0);
        check_eq("lw_3c_exc", 32'(bus.EXC_W), 32'd0);

        // Word round trip, back to back.
        do_op(6'h2B, 32'h10, 32'hDEAD_BEEF, 32'h1004, 1'b1);
        check_eq("sw_rdata", bus.MEM_READ_DATA_W, 32'h0);
        do_op(6'h23, 32'h10, 32'h0, 32'h1008, 1'b0);
        check_eq("lw_10", bus.MEM_READ_DATA_W, 32'hDEAD_BEEF);

        // Byte and half extension.
        do_op(6'h28, 32'h21, 32'h1234_5680, 32'h100C, 1'b1);
        do_op(6'h20, 32'h21, 32'h0, 32'h1010, 1'b0);
        check_eq("lb_21", bus.MEM_READ_DATA_W, 32'hFFFF_FF80);
        do_op(6'h24, 32'h21, 32'h0, 32'h1014, 1'b0);
        check_eq("lbu_21", bus.MEM_READ_DATA_W, 32'h0000_0080);
        do_op(6'h23, 32'h20, 32'h0, 32'h1018, 1'b0);
        check_eq("lw_20_sb", bus.MEM_READ_DATA_W, 32'h0000_8000);
        do_op(6'h29, 32'h22, 32'hABCD_8001, 32'h101C, 1'b1);
        do_op(6'h21, 32'h22, 32'h0, 32'h1020, 1'b0);
        check_eq("lh_22", bus.MEM_READ_DATA_W, 32'hFFFF_8001);
        do_op(6'h25, 32'h22, 32'h0, 32'h1024, 1'b0);
        check_eq("lhu_22", bus.MEM_READ_DATA_W, 32'h0000_8001);
        do_op(6'h23, 32'h20, 32'h0, 32'h1028, 1'b0);
        check_eq("lw_20_sh", bus.MEM_READ_DATA_W, 32'h8001_8000);

        // Misaligned word load.
        do_op(6'h23, 32'h13, 32'h0, 32'h3004, 1'b0);
        check_eq("lw13_exc", 32'(bus.EXC_W), 32'd1);
        check_eq("lw13_pc", bus.EXC_PC_W, 32'h3004);
        check_eq("lw13_bad", bus.BAD_ADDR_W, 32'h13);
        check_eq("lw13_data", bus.MEM_READ_DATA_W, 32'h0);
        do_op(6'h00, 32'h0, 32'h0, 32'h5000, 1'b0);
        check_eq("nop_exc_clr", 32'(bus.EXC_W), 32'd0);
        check_eq("nop_pc_hold", bus.EXC_PC_W, 32'h3004);
        check_eq("nop_bad_hold", bus.BAD_ADDR_W, 32'h13);

        // Misaligned halfword store is suppressed.
        do_op(6'h29, 32'h11, 32'h0000_FFFF, 32'h3008, 1'b1);
        check_eq("sh11_exc", 32'(bus.EXC_W), 32'd1);
        check_eq("sh11_bad", bus.BAD_ADDR_W, 32'h11);
        do_op(6'h23, 32'h10, 32'h0, 32'h300C, 1'b0);
        check_eq("sh11_mem", bus.MEM_READ_DATA_W, 32'hDEAD_BEEF);
        check_eq("sh11_exc_clr", 32'(bus.EXC_W), 32'd0);

        // Out-of-range store would alias word 0 if it leaked through.
        do_op(6'h2B, 32'h40, 32'h5555_5555, 32'h3010, 1'b1);
        check_eq("sw40_exc", 32'(bus.EXC_W), 32'd1);
        check_eq("sw40_pc", bus.EXC_PC_W, 32'h3010);
        do_op(6'h23, 32'h00, 32'h0, 32'h3014, 1'b0);
        check_eq("sw40_nowrite", bus.MEM_READ_DATA_W, 32'h0);

        // Disabled misaligned store: no exception, no write.
        do_op(6'h2B, 32'h13, 32'h1111_1111, 32'h3018, 1'b0);
        check_eq("sw_dis_exc", 32'(bus.EXC_W), 32'd0);
        do_op(6'h2B, 32'h10, 32'h2222_2222, 32'h301C, 1'b0);
        do_op(6'h23, 32'h10, 32'h0, 32'h3020, 1'b0);
        check_eq("sw_dis_mem", bus.MEM_READ_DATA_W, 32'hDEAD_BEEF);

        // Non-memory opcode returns 0.
        do_op(6'h00, 32'h10, 32'h0, 32'h3024, 1'b0);
        check_eq("nop_data", bus.MEM_READ_DATA_W, 32'h0);

        // BASE_ADDR - 4 wraps out of range.
        do_op(6'h23, 32'hFFFF_FFFC, 32'h0, 32'h3028, 1'b0);
        check_eq("wrap_exc", 32'(bus.EXC_W), 32'd1);
        check_eq("wrap_bad", bus.BAD_ADDR_W, 32'hFFFF_FFFC);

        // Reset during run clears W outputs immediately.
        reset = 1'b0;
        #1;
        check_eq("rrun_exc", 32'(bus.EXC_W), 32'd0);
        check_eq("rrun_pc", bus.EXC_PC_W, 32'h0);
        check_eq("rrun_stall", 32'(bus.STALL_M), 32'd1);

        // Reset again at sweep index 5.
        bus.INSTR_M             = {6'h2B, 26'h0};
        bus.ALU_OUT_M           = 32'h14;
        bus.FRead_Data_2_M      = 32'hFFFF_FFFF;
        bus.MEM_WRITE_ENABLED_M = 1'b1;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        #1;
        check_eq("rmid_stall", 32'(bus.STALL_M), 32'd1);
        check_eq("rmid_rdata", bus.MEM_READ_DATA_W, 32'h0);
        tick();
        reset = 1'b1;
        wait_sweep(n_stall, leak);
        check_eq("resweep_len", 32'(n_stall), 32'd16);
        check_eq("resweep_hold", 32'(leak), 32'd0);
        do_op(6'h23, 32'h10, 32'h0, 32'h4000, 1'b0);
        check_eq("resweep_clr10", bus.MEM_READ_DATA_W, 32'h0);
        do_op(6'h23, 32'h14, 32'h0, 32'h4004, 1'b0);
        check_eq("resweep_clr14", bus.MEM_READ_DATA_W, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
